reg_store_serializer: RTL and testbench
=======================================

// Module: reg_store_serializer
// PURPOSE
//  Store-side counterpart of the byte-wise register loads: takes a 16-bit register value and
//  writes it to byte-wide memory as one or two byte writes. Low byte goes to base address,
//  high byte to base+1 (little-endian).
//  Sits between the register file/ALU output bus and the 8-bit data memory write port.
//  Driven by the control unit with a Start pulse; reports Busy and a one-cycle Done.
// PARAMETERS
//  DATA_WIDTH  16  register width (two bytes; other values unsupported)
//  ADDR_WIDTH  16  memory address width
//  HI_FIRST    0   0: low byte at base address, high at base+1; 1: high byte at base address
// PORTS
//  Clock     in   1   single clock, all state updates on posedge
//  Reset     in   1   asynchronous, active-high; clears all state and outputs
//  Start     in   1   request a store; sampled only in IDLE
//  Mode      in   1   0: word store (2 bytes); 1: byte store (low byte I[7:0] only)
//  Data      in   16  value to store; captured on accepted Start
//  Address   in   16  base byte address; captured on accepted Start
//  MemReady  in   1   memory accepts the current byte when MemWR & MemReady at posedge
//  MemAddr   out  16  byte address presented to memory
//  MemData   out  8   byte presented to memory
//  MemWR     out  1   write strobe, high while a byte is pending
//  Busy      out  1   high in WR_FIRST and WR_SECOND
//  Done      out  1   one-cycle pulse after final byte accepted
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, MemAddr=0, MemData=0, MemWR=0, Busy=0, Done=0.
//    An in-flight store is abandoned; no further byte is written after Reset deasserts.
//  - States: IDLE -> WR_FIRST -> [WR_SECOND] -> DONE -> IDLE. All outputs are registered.
//  - IDLE: on Start=1 latch Data, Address, Mode; go WR_FIRST next edge. Start=0: stay.
//  - WR_FIRST: MemWR=1, MemAddr=base, MemData=first byte (HI_FIRST selects). Hold all
//    outputs stable while MemReady=0 (unbounded stall). On MemReady=1: Mode=1 -> DONE,
//    Mode=0 -> WR_SECOND.
//  - WR_SECOND: MemWR=1, MemAddr=base+1 (mod 2^16, 0xFFFF wraps to 0x0000),
//    MemData=other byte. Stall rule identical; on MemReady=1 -> DONE.
//  - DONE: MemWR=0, Busy=0, Done=1 for exactly one cycle, then IDLE.
//  - Start while Busy or in DONE is ignored (not queued). Data/Address changes after
//    acceptance have no effect on the store in progress.
//  - Latency with MemReady tied 1: Start sampled at edge k -> first byte strobed cycle k+1,
//    second k+2, Done high cycle k+3. Byte store: Done at k+2. Earliest next Start: IDLE
//    cycle after Done.
//  - In byte mode the high byte of Data is never driven onto MemData.
//  - MemData/MemAddr hold their last values in IDLE/DONE; consumers qualify with MemWR.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE=2'b00, WR_FIRST=2'b01, WR_SECOND=2'b10,
//    DONE=2'b11), Mode constants (MODE_WORD=1'b0, MODE_BYTE=1'b1).
//  - Single module, one FSM plus capture registers; no sub-module warranted (the address
//    +1 and byte select are one-liners).
// TESTING
//  - Word store: Data=16'hABCD, Address=16'h0010, MemReady=1 -> (0x0010,0xCD) then
//    (0x0011,0xAB), Done at k+3.
//  - Byte store: Mode=1, Data=16'h12F7, Address=16'h0200 -> single write (0x0200,0xF7),
//    no second MemWR, Done at k+2.
//  - Stall + wrap: Address=16'hFFFF, MemReady low 3 cycles each byte -> outputs stable
//    while stalled; writes (0xFFFF,lo) then (0x0000,hi).
//  - Ignored Start: Start pulsed during WR_SECOND and in DONE with new Data -> no extra
//    writes, original bytes unchanged.
//  - Reset mid-op: Reset asserted asynchronously in WR_FIRST (MemReady=0) -> MemWR=0,
//    Busy=0 immediately, no write afterward, next Start works normally.
//  - HI_FIRST=1 instance: Data=16'h5A3C, Address=16'h0100 -> (0x0100,0x5A), (0x0101,0x3C).

Source files
------------

// File: rtl/reg_store_serializer_pkg.sv
// Shared encodings for the register store serializer: FSM states, store modes
// and the byte-lane select helper.
package reg_store_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WR_FIRST  = 2'b01,
    WR_SECOND = 2'b10,
    DONE      = 2'b11
  } state_t;

  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  function automatic logic [7:0] pick_byte(input logic [15:0] value, input logic high);
    return high ? value[15:8] : value[7:0];
  endfunction

endpackage

// File: rtl/reg_store_serializer.sv
// Splits a 16-bit register value into one or two byte writes on an 8-bit
// memory write port, with a ready/strobe handshake and a one-cycle Done.
//
// state     | meaning
// IDLE      | waiting for Start; memory outputs hold their last values
// WR_FIRST  | strobing the byte at the base address, waiting for MemReady
// WR_SECOND | strobing the byte at base+1, waiting for MemReady
// DONE      | Done pulse for one cycle, then back to IDLE
module reg_store_serializer
  import reg_store_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter bit HI_FIRST   = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Mode,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemData,
  output logic                  MemWR,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic HI_SEL = (HI_FIRST != 1'b0);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  mode_q, mode_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [7:0]            mem_data_nxt;
  logic                  mem_wr_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      mode_q  <= MODE_WORD;
      MemAddr <= '0;
      MemData <= '0;
      MemWR   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_q  <= data_nxt;
      addr_q  <= addr_nxt;
      mode_q  <= mode_nxt;
      MemAddr <= mem_addr_nxt;
      MemData <= mem_data_nxt;
      MemWR   <= mem_wr_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

  // Outputs are registered, so each branch computes what the next state presents.
  always_comb begin
    state_nxt    = state;
    data_nxt     = data_q;
    addr_nxt     = addr_q;
    mode_nxt     = mode_q;
    mem_addr_nxt = MemAddr;
    mem_data_nxt = MemData;
    mem_wr_nxt   = MemWR;
    busy_nxt     = Busy;
    done_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        if (Start) begin
          data_nxt     = Data;
          addr_nxt     = Address;
          mode_nxt     = Mode;
          mem_addr_nxt = Address;
          // A byte store always writes the low byte, whatever the lane order.
          mem_data_nxt = pick_byte(Data, HI_SEL && (Mode == MODE_WORD));
          mem_wr_nxt   = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = WR_FIRST;
        end
      end
      WR_FIRST: begin
        if (MemReady) begin
          if (mode_q == MODE_BYTE) begin
            mem_wr_nxt = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = DONE;
          end else begin
            mem_addr_nxt = addr_q + ADDR_WIDTH'(1);
            mem_data_nxt = pick_byte(data_q, !HI_SEL);
            state_nxt    = WR_SECOND;
          end
        end
      end
      WR_SECOND: begin
        if (MemReady) begin
          mem_wr_nxt = 1'b0;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_store_serializer.sv
// Bench for reg_store_serializer: a queue-of-pending-writes model drives a
// per-cycle compare of two instances (low-first and high-first lane order).
module tb_reg_store_serializer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Mode;
  logic [15:0] Data;
  logic [15:0] Address;
  logic        MemReady;

  logic [15:0] MemAddr0, MemAddr1;
  logic [7:0]  MemData0, MemData1;
  logic        MemWR0, MemWR1, Busy0, Busy1, Done0, Done1;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  always #5 Clock = ~Clock;

  reg_store_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .HI_FIRST(1'b0)) dut_lo (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Data(Data),
    .Address(Address), .MemReady(MemReady), .MemAddr(MemAddr0), .MemData(MemData0),
    .MemWR(MemWR0), .Busy(Busy0), .Done(Done0)
  );

  reg_store_serializer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .HI_FIRST(1'b1)) dut_hi (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode), .Data(Data),
    .Address(Address), .MemReady(MemReady), .MemAddr(MemAddr1), .MemData(MemData1),
    .MemWR(MemWR1), .Busy(Busy1), .Done(Done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a list of {addr,byte} writes still owed, plus a pending Done pulse.
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] last0, last1;
  bit          m_done;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q0.delete();
      q1.delete();
      m_done = 1'b0;
      last0  = '0;
      last1  = '0;
    end else begin
      ecount++;
      begin
        bit          idle;
        logic [15:0] a1;
        idle   = (q0.size() == 0) && !m_done;
        m_done = 1'b0;
        a1     = Address + 16'd1;
        if (q0.size() > 0 && MemReady) begin
          last0 = q0.pop_front();
          last1 = q1.pop_front();
          if (q0.size() == 0) m_done = 1'b1;
        end else if (idle && Start) begin
          if (Mode) begin
            q0.push_back({Address, Data[7:0]});
            q1.push_back({Address, Data[7:0]});
          end else begin
            q0.push_back({Address, Data[7:0]});
            q0.push_back({a1, Data[15:8]});
            q1.push_back({Address, Data[15:8]});
            q1.push_back({a1, Data[7:0]});
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    bit pend;
    pend = (q0.size() > 0);
    check("memwr_lo", 32'(MemWR0), 32'(pend));
    check("memwr_hi", 32'(MemWR1), 32'(pend));
    check("busy_lo", 32'(Busy0), 32'(pend));
    check("busy_hi", 32'(Busy1), 32'(pend));
    check("done_lo", 32'(Done0), 32'(m_done));
    check("done_hi", 32'(Done1), 32'(m_done));
    if (pend) begin
      check("addr_lo", 32'(MemAddr0), 32'(q0[0][23:8]));
      check("data_lo", 32'(MemData0), 32'(q0[0][7:0]));
      check("addr_hi", 32'(MemAddr1), 32'(q1[0][23:8]));
      check("data_hi", 32'(MemData1), 32'(q1[0][7:0]));
    end else begin
      check("hold_lo", 32'({MemAddr0, MemData0}), 32'(last0));
      check("hold_hi", 32'({MemAddr1, MemData1}), 32'(last1));
    end
  end

  // Log of bytes actually accepted by memory, for the literal expectations.
  logic [23:0] log0[$];
  logic [23:0] log1[$];

  always @(posedge Clock) begin
    if (!Reset && MemWR0 && MemReady) log0.push_back({MemAddr0, MemData0});
    if (!Reset && MemWR1 && MemReady) log1.push_back({MemAddr1, MemData1});
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_store(input logic m, input logic [15:0] d, input logic [15:0] a,
                             output int e_acc);
    Start   = 1'b1;
    Mode    = m;
    Data    = d;
    Address = a;
    tick();
    e_acc   = ecount;
    Start   = 1'b0;
    Data    = 16'($urandom);
    Address = 16'($urandom);
  endtask

  task automatic wait_done(input int max, output int e_done);
    e_done = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge Clock);
      if (Done0) begin
        e_done = ecount;
        break;
      end
    end
    if (e_done < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no Done within %0d cycles at %0t", max, $time);
    end
  endtask

  task automatic check_log(input string name, input int n,
                           input logic [23:0] e0a, input logic [23:0] e0b,
                           input logic [23:0] e1a, input logic [23:0] e1b);
    check({name, "_count_lo"}, 32'(log0.size()), 32'(n));
    check({name, "_count_hi"}, 32'(log1.size()), 32'(n));
    if (log0.size() >= 1) check({name, "_w0_lo"}, 32'(log0[0]), 32'(e0a));
    if (log1.size() >= 1) check({name, "_w0_hi"}, 32'(log1[0]), 32'(e1a));
    if (n == 2 && log0.size() >= 2) check({name, "_w1_lo"}, 32'(log0[1]), 32'(e0b));
    if (n == 2 && log1.size() >= 2) check({name, "_w1_hi"}, 32'(log1[1]), 32'(e1b));
  endtask

  initial begin
    int ea, ed;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Data = '0; Address = '0; MemReady = 1'b1;
    tick(); tick();
    check("reset_outputs_lo", 32'({MemAddr0, MemData0, MemWR0, Busy0, Done0}), 32'd0);
    check("reset_outputs_hi", 32'({MemAddr1, MemData1, MemWR1, Busy1, Done1}), 32'd0);
    #2 Reset = 1'b0;
    tick(); tick();

    // Word store with ready tied high
    log0.delete(); log1.delete();
    start_store(1'b0, 16'hABCD, 16'h0010, ea);
    wait_done(20, ed);
    check("word_latency", 32'(ed - ea), 32'd2);
    tick(); tick();
    check_log("word", 2, 24'h0010CD, 24'h0011AB, 24'h0010AB, 24'h0011CD);

    // Byte store: only the low byte, one strobe
    log0.delete(); log1.delete();
    start_store(1'b1, 16'h12F7, 16'h0200, ea);
    wait_done(20, ed);
    check("byte_latency", 32'(ed - ea), 32'd1);
    tick(); tick();
    check_log("byte", 1, 24'h0200F7, 24'h0, 24'h0200F7, 24'h0);

    // Stall three cycles on each byte, base address wraps
    log0.delete(); log1.delete();
    MemReady = 1'b0;
    start_store(1'b0, 16'h1234, 16'hFFFF, ea);
    repeat (3) tick();
    MemReady = 1'b1;
    tick();
    MemReady = 1'b0;
    repeat (3) tick();
    MemReady = 1'b1;
    wait_done(20, ed);
    tick(); tick();
    check_log("wrap", 2, 24'hFFFF34, 24'h000012, 24'hFFFF12, 24'h000034);

    // Start during WR_SECOND and DONE must be ignored
    log0.delete(); log1.delete();
    start_store(1'b0, 16'h5A3C, 16'h0100, ea);
    tick();
    Start = 1'b1; Data = 16'h9999; Address = 16'h0400;
    tick();
    Data = 16'h7777; Address = 16'h0500;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    check_log("ignored", 2, 24'h01003C, 24'h01015A, 24'h01005A, 24'h01013C);

    // Asynchronous reset while stalled in WR_FIRST
    log0.delete(); log1.delete();
    MemReady = 1'b0;
    start_store(1'b0, 16'hBEEF, 16'h0030, ea);
    #2 Reset = 1'b1;
    #1;
    check("rst_memwr_lo", 32'(MemWR0), 32'd0);
    check("rst_busy_lo", 32'(Busy0), 32'd0);
    check("rst_memwr_hi", 32'(MemWR1), 32'd0);
    MemReady = 1'b1;
    tick(); tick();
    #2 Reset = 1'b0;
    repeat (3) tick();
    check("rst_no_write", 32'(log0.size() + log1.size()), 32'd0);
    start_store(1'b0, 16'h0F0E, 16'h0300, ea);
    wait_done(20, ed);
    check("post_rst_latency", 32'(ed - ea), 32'd2);
    tick(); tick();
    check_log("post_rst", 2, 24'h03000E, 24'h03010F, 24'h03000F, 24'h03010E);

    // Random traffic against the model, with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      tick();
      Start    = ($urandom_range(0, 3) == 0);
      Mode     = 1'($urandom);
      Data     = 16'($urandom);
      Address  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      MemReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 96) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
    end
    Start = 1'b0;
    MemReady = 1'b1;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
